rep3_tx: RTL and testbench

Serial transmitter for a triple-repetition line code: each accepted data word is framed (start, data LSB-first, stop) and every framed bit is sent as three identical consecutive chips. It is the sending end of the 2-of-3 majority-vote receive path; a downstream receiver recovers each bit by voting on the three chips. It sits between a valid/ready word source and a single-wire serial output.

---
 rtl/rep3_tx.sv | 144 ++++++++++++++
 tb/tb_rep3_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rep3_tx.sv
// rep3_tx: framed serial transmitter (start, data LSB-first, optional parity, stop);
// every framed bit is sent as three identical chips. Optional parity: REP3_PARITY_EN.
`default_nettype none

module rep3_tx #(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              done
);

  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

`ifdef REP3_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  state_t            state;
  state_t            next_state;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        rep_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              chip_end;
  logic              bit_end;
`ifdef REP3_PARITY_EN
  logic              parity;
`endif

  assign chip_end = (div_cnt == DIV_MAX);
  assign bit_end  = chip_end && (rep_cnt == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (in_valid) next_state = ST_START;
      ST_START: if (bit_end) next_state = ST_DATA;
      ST_DATA: begin
        if (bit_end && (bit_cnt == BIT_MAX)) begin
`ifdef REP3_PARITY_EN
          next_state = ST_PARITY;
`else
          next_state = ST_STOP;
`endif
        end
      end
`ifdef REP3_PARITY_EN
      ST_PARITY: if (bit_end) next_state = ST_STOP;
`endif
      ST_STOP:  if (bit_end) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Counters only run mid-frame; IDLE keeps them cleared so a new frame starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      rep_cnt   <= 2'd0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      done      <= 1'b0;
`ifdef REP3_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      done <= (state == ST_STOP) && bit_end;
      if (state == ST_IDLE) begin
        div_cnt <= '0;
        rep_cnt <= 2'd0;
        bit_cnt <= '0;
        if (in_valid) begin
          shift_reg <= in_data;
`ifdef REP3_PARITY_EN
          parity    <= ^in_data;
`endif
        end
      end else begin
        if (chip_end) begin
          div_cnt <= '0;
          rep_cnt <= (rep_cnt == 2'd2) ? 2'd0 : rep_cnt + 2'd1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if ((state == ST_DATA) && bit_end) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
        end
      end
    end
  end

  // Decoded from state so an asynchronous reset forces the line high immediately.
  always_comb begin
    tx_out = 1'b1;
    case (state)
      ST_IDLE:   tx_out = 1'b1;
      ST_START:  tx_out = 1'b0;
      ST_DATA:   tx_out = shift_reg[0];
`ifdef REP3_PARITY_EN
      ST_PARITY: tx_out = parity;
`endif
      ST_STOP:   tx_out = 1'b1;
      default:   tx_out = 1'b1;
    endcase
  end

  assign in_ready = (state == ST_IDLE);
  assign tx_busy  = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rep3_tx.sv
// tb_rep3_tx: self-checking bench for rep3_tx against a bit-list frame model.
`default_nettype none

module tb_rep3_tx;

  localparam int DATA_W   = 8;
  localparam int BAUD_DIV = 4;
`ifdef REP3_PARITY_EN
  localparam int NBITS = DATA_W + 3;
`else
  localparam int NBITS = DATA_W + 2;
`endif
  localparam int F = 3 * NBITS * BAUD_DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              tx_out;
  logic              tx_busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  rep3_tx #(.DATA_W(DATA_W), .BAUD_DIV(BAUD_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Expected line level at clock t of a frame carrying word w.
  function automatic logic exp_tx(input logic [DATA_W-1:0] w, input int t);
    int b;
    b = t / (3 * BAUD_DIV);
    if (b == 0) return 1'b0;
    if (b <= DATA_W) return w[b-1];
`ifdef REP3_PARITY_EN
    if (b == DATA_W + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_tx"}, tx_out, 1'b1);
    chk({tag, "_ready"}, in_ready, 1'b1);
    chk({tag, "_busy"}, tx_busy, 1'b0);
    chk({tag, "_done"}, done, exp_done);
  endtask

  // Present a word while idle; returns #1 after the accept edge.
  task automatic accept(input logic [DATA_W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Entered #1 after accept edge E. Inputs are scrambled throughout the frame.
  task automatic run_frame(input logic [DATA_W-1:0] w, input bit chain,
                           input logic [DATA_W-1:0] nxt);
    for (int t = 0; t < F; t++) begin
      chk("frame_tx", tx_out, exp_tx(w, t));
      chk("frame_busy", tx_busy, 1'b1);
      chk("frame_ready", in_ready, 1'b0);
      chk("frame_done", done, 1'b0);
      in_data  = DATA_W'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    chk_idle("end", 1'b1);
    in_valid = chain;
    in_data  = chain ? nxt : DATA_W'($urandom);
    @(posedge clk); #1;
    if (!chain) begin
      in_valid = 1'b0;
      chk_idle("post", 1'b0);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] w0, w1;

    // Reset held for 5 cycles, then released with no traffic.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_idle("rst", 1'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_idle("quiet", 1'b0);
    end

    // Single directed frame.
    accept(8'hA5);
    run_frame(8'hA5, 1'b0, '0);

    // Back-to-back with in_valid held through the done cycle.
    accept(8'h00);
    run_frame(8'h00, 1'b1, 8'hFF);
    run_frame(8'hFF, 1'b0, '0);

    // Input scrambling during a known frame.
    accept(8'h3C);
    run_frame(8'h3C, 1'b0, '0);

    // Parity-relevant words.
    accept(8'h01);
    run_frame(8'h01, 1'b0, '0);

    // Reset 50 clocks into a frame of zeros (line is low at that point).
    accept(8'h00);
    for (int t = 0; t < 50; t++) begin
      chk("pre_rst_tx", tx_out, exp_tx(8'h00, t));
      @(posedge clk); #1;
    end
    chk("pre_rst_low", tx_out, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_idle("in_rst", 1'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("after_rst", 1'b0);
    accept(8'h5A);
    run_frame(8'h5A, 1'b0, '0);

    // Random words, alternately chained and separated.
    w0 = DATA_W'($urandom);
    accept(w0);
    for (int n = 0; n < 6; n++) begin
      w1 = DATA_W'($urandom);
      if (n % 2 == 0) begin
        run_frame(w0, 1'b1, w1);
      end else begin
        run_frame(w0, 1'b0, '0);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
          chk_idle("gap", 1'b0);
        end
        accept(w1);
      end
      w0 = w1;
    end
    run_frame(w0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
